// File: rtl/ysyx_25060170_ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem read in flight,
// and buffers the returned word for decode over a valid/ready handshake.
module ysyx_25060170_ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_fault,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            drop, drop_n;
  logic [31:0]     count_n;
  logic            load;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      fetch_count <= '0;
      if_pc       <= '0;
      if_inst     <= '0;
      if_fault    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop        <= drop_n;
      fetch_count <= count_n;
      if (load) begin
        if_pc    <= pc;
        if_inst  <= imem_rsp_data;
        if_fault <= imem_rsp_err;
      end
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    drop_n         = drop;
    count_n        = fetch_count;
    load           = 1'b0;
    imem_req_valid = 1'b0;
    unique case (state)
      S_REQ: begin
        imem_req_valid = ~redirect_valid;
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n   = redirect_pc;
          drop_n = 1'b1;
        end
        // A redirect coinciding with the response squashes it just like a stale drop.
        if (imem_rsp_valid) begin
          if (drop || redirect_valid) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            load    = 1'b1;
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else if (if_ready) begin
          pc_n    = pc + XLEN'(4);
          count_n = fetch_count + 32'd1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  assign imem_req_addr = pc;
  assign if_valid      = (state == S_HOLD);

endmodule
